// File: rtl/ctrl_seq_pkg.sv
// Shared encodings for the multi-cycle control sequencer.
//   state_t   : sequencer state, 4-bit, values fixed for datapath/debug visibility
//   EXC_*     : exception cause codes reported on exc_cause
package ctrl_seq_pkg;

  localparam int STATE_W = 4;
  localparam int CAUSE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    PAUSE     = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    JUDGE     = 4'd3,
    EXEC      = 4'd4,
    MD_WAIT   = 4'd5,
    MEM_WAIT  = 4'd6,
    WRITEBACK = 4'd7,
    TRAP      = 4'd8
  } state_t;

  localparam logic [CAUSE_W-1:0] EXC_NONE    = 2'b00;
  localparam logic [CAUSE_W-1:0] EXC_TRAP    = 2'b01;
  localparam logic [CAUSE_W-1:0] EXC_TIMEOUT = 2'b10;

  // States that wait on an external handshake and are policed by the watchdog.
  function automatic logic is_wait_state(state_t s);
    return (s == FETCH) || (s == MD_WAIT) || (s == MEM_WAIT);
  endfunction

endpackage

// File: rtl/wait_watchdog.sv
// Wait-state watchdog.
//   clk, reset : falling-edge clock, async active-high reset
//   clear      : zero the counter (asserted on any state change)
//   count_en   : FSM is sitting in a wait state this cycle
//   expired    : this is the MAX_WAIT-th consecutive waiting cycle
// The counter holds the number of waiting cycles already spent, so expired
// fires on the last permitted cycle; the FSM still lets a ready/done that
// arrives on that same cycle take priority over the timeout.
module wait_watchdog #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] cnt_q;

  assign expired = count_en && (cnt_q == LAST);

  always_ff @(negedge clk or posedge reset) begin
    if (reset)                    cnt_q <= '0;
    else if (clear)               cnt_q <= '0;
    else if (count_en && !expired) cnt_q <= cnt_q + WAIT_W'(1);
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle CPU control sequencer with variable-latency handshakes.
// Issues sequencing strobes only; mux selects live in the datapath decoder.
//   clk, reset        : state advances on the falling edge; async active-high reset
//   run_en            : sampled whenever the FSM would enter FETCH; 0 parks in PAUSE
//   imem_ready, dmem_ready, md_done : handshakes, honoured only in their wait state
//   cls_*, branch_taken, exception_valid : decoded instruction class / status
//   state             : current state (ctrl_seq_pkg encoding)
//   imem_req..exc_req : sequencing strobes (Moore per state, Mealy on handshakes)
//   exc_cause         : 00 none, 01 trap, 10 watchdog timeout
//   retired           : retired-instruction count, wraps
module multicycle_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int RET_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_en,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               md_done,
  input  logic               cls_branch,
  input  logic               branch_taken,
  input  logic               cls_mem,
  input  logic               cls_store,
  input  logic               cls_muldiv,
  input  logic               cls_jump,
  input  logic               cls_link,
  input  logic               cls_trap,
  input  logic               exception_valid,
  input  logic               cls_wb,
  output logic [STATE_W-1:0] state,
  output logic               imem_req,
  output logic               ir_wena,
  output logic               pc_enable,
  output logic               y_ena,
  output logic               regfile_wena,
  output logic               dmem_req,
  output logic               dmem_wena,
  output logic               md_start,
  output logic               hilo_wena,
  output logic               exc_req,
  output logic [CAUSE_W-1:0] exc_cause,
  output logic [RET_W-1:0]   retired
);

  state_t             st_q, st_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [RET_W-1:0]   ret_q;
  logic               retire;
  logic               expired;
  state_t             fetch_nxt;

  wait_watchdog #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .clear    (st_d != st_q),
    .count_en (is_wait_state(st_q)),
    .expired  (expired)
  );

  // Every path back to FETCH goes through here so run_en is only looked at
  // between instructions.
  assign fetch_nxt = run_en ? FETCH : PAUSE;

  always_comb begin
    st_d         = st_q;
    cause_d      = cause_q;
    retire       = 1'b0;
    imem_req     = 1'b0;
    ir_wena      = 1'b0;
    pc_enable    = 1'b0;
    y_ena        = 1'b0;
    regfile_wena = 1'b0;
    dmem_req     = 1'b0;
    dmem_wena    = 1'b0;
    md_start     = 1'b0;
    hilo_wena    = 1'b0;
    exc_req      = 1'b0;
    unique case (st_q)
      PAUSE: if (run_en) st_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        y_ena    = 1'b1;                 // ALU computes PC+4
        if (imem_ready) begin
          ir_wena = 1'b1;
          cause_d = EXC_NONE;            // a reported cause lives until we fetch past it
          st_d    = DECODE;
        end else if (expired) begin
          cause_d = EXC_TIMEOUT;
          st_d    = TRAP;
        end
      end
      DECODE: begin
        pc_enable = 1'b1;
        st_d      = cls_branch ? JUDGE : EXEC;
      end
      JUDGE: begin
        y_ena = 1'b1;                    // branch target into Y
        if (branch_taken) st_d = EXEC;
        else begin
          st_d   = fetch_nxt;
          retire = 1'b1;
        end
      end
      EXEC: begin
        if (cls_trap) begin
          if (exception_valid) begin
            cause_d = EXC_TRAP;
            st_d    = TRAP;
          end else begin
            st_d   = fetch_nxt;
            retire = 1'b1;
          end
        end else if (cls_muldiv) begin
          md_start = 1'b1;
          st_d     = MD_WAIT;
        end else if (cls_mem) begin
          dmem_req = 1'b1;
          st_d     = MEM_WAIT;
        end else if (cls_jump) begin
          pc_enable    = 1'b1;
          regfile_wena = cls_link;
          st_d         = fetch_nxt;
          retire       = 1'b1;
        end else begin
          y_ena = 1'b1;
          st_d  = WRITEBACK;
        end
      end
      MD_WAIT: begin
        if (md_done) begin
          hilo_wena = 1'b1;
          st_d      = fetch_nxt;
          retire    = 1'b1;
        end else if (expired) begin
          cause_d = EXC_TIMEOUT;
          st_d    = TRAP;
        end
      end
      MEM_WAIT: begin
        dmem_req  = 1'b1;
        dmem_wena = cls_store;
        if (dmem_ready) st_d = WRITEBACK;
        else if (expired) begin
          cause_d = EXC_TIMEOUT;
          st_d    = TRAP;
        end
      end
      WRITEBACK: begin
        regfile_wena = cls_wb & ~cls_store;
        pc_enable    = cls_branch;       // taken branch loads its target
        st_d         = fetch_nxt;
        retire       = 1'b1;
      end
      TRAP: begin
        exc_req   = 1'b1;
        pc_enable = 1'b1;                // exception vector
        st_d      = fetch_nxt;
      end
      default: st_d = PAUSE;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= PAUSE;
      cause_q <= EXC_NONE;
      ret_q   <= '0;
    end else begin
      st_q    <= st_d;
      cause_q <= cause_d;
      if (retire) ret_q <= ret_q + RET_W'(1);
    end
  end

  assign state     = st_q;
  assign exc_cause = cause_q;
  assign retired   = ret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: dut_a (MAX_WAIT=40, RET_W=4) and dut_b (MAX_WAIT=15, RET_W=32)
// share all inputs. Inputs change at posedge+1, outputs are sampled at
// posedge+2; DUT state moves on the falling edge.
module tb_multicycle_sequencer;

  localparam int ST_PAUSE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_JUDGE = 3, ST_EXEC = 4;
  localparam int ST_MDW = 5, ST_MEMW = 6, ST_WB = 7, ST_TRAP = 8;

  // strobe vector order: imem_req ir_wena pc_enable y_ena regfile_wena
  //                      dmem_req dmem_wena md_start hilo_wena exc_req
  localparam logic [9:0] B_IREQ = 10'h200, B_IRW = 10'h100, B_PC = 10'h080, B_Y = 10'h040;
  localparam logic [9:0] B_RF = 10'h020, B_DREQ = 10'h010, B_DW = 10'h008, B_MDS = 10'h004;
  localparam logic [9:0] B_HILO = 10'h002, B_EXC = 10'h001;
  localparam logic [9:0] FETCH_SB = B_IREQ | B_IRW | B_Y;

  logic clk = 1'b1, reset = 1'b1, run_en = 1'b0;
  logic imem_ready = 0, dmem_ready = 0, md_done = 0, cls_branch = 0, branch_taken = 0;
  logic cls_mem = 0, cls_store = 0, cls_muldiv = 0, cls_jump = 0, cls_link = 0;
  logic cls_trap = 0, exception_valid = 0, cls_wb = 0;

  wire [3:0]  st_a, st_b;
  wire [9:0]  sb_a, sb_b;
  wire [1:0]  ca_a, ca_b;
  wire [3:0]  ret_a;
  wire [31:0] ret_b;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MAX_WAIT(40), .WAIT_W(6), .RET_W(4)) dut_a (
    .clk(clk), .reset(reset), .run_en(run_en), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .md_done(md_done), .cls_branch(cls_branch),
    .branch_taken(branch_taken), .cls_mem(cls_mem), .cls_store(cls_store),
    .cls_muldiv(cls_muldiv), .cls_jump(cls_jump), .cls_link(cls_link),
    .cls_trap(cls_trap), .exception_valid(exception_valid), .cls_wb(cls_wb),
    .state(st_a), .imem_req(sb_a[9]), .ir_wena(sb_a[8]), .pc_enable(sb_a[7]),
    .y_ena(sb_a[6]), .regfile_wena(sb_a[5]), .dmem_req(sb_a[4]), .dmem_wena(sb_a[3]),
    .md_start(sb_a[2]), .hilo_wena(sb_a[1]), .exc_req(sb_a[0]),
    .exc_cause(ca_a), .retired(ret_a)
  );

  multicycle_sequencer #(.MAX_WAIT(15), .WAIT_W(4), .RET_W(32)) dut_b (
    .clk(clk), .reset(reset), .run_en(run_en), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .md_done(md_done), .cls_branch(cls_branch),
    .branch_taken(branch_taken), .cls_mem(cls_mem), .cls_store(cls_store),
    .cls_muldiv(cls_muldiv), .cls_jump(cls_jump), .cls_link(cls_link),
    .cls_trap(cls_trap), .exception_valid(exception_valid), .cls_wb(cls_wb),
    .state(st_b), .imem_req(sb_b[9]), .ir_wena(sb_b[8]), .pc_enable(sb_b[7]),
    .y_ena(sb_b[6]), .regfile_wena(sb_b[5]), .dmem_req(sb_b[4]), .dmem_wena(sb_b[3]),
    .md_start(sb_b[2]), .hilo_wena(sb_b[1]), .exc_req(sb_b[0]),
    .exc_cause(ca_b), .retired(ret_b)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  // check dut_a state + strobes for the current cycle, then advance one cycle
  task automatic cyc(string tag, int st, logic [9:0] sb);
    #1;
    chk({tag, ".st"}, 32'(st_a), st);
    chk({tag, ".sb"}, 32'(sb_a), 32'(sb));
    nx();
  endtask

  task automatic rst();
    run_en = 0; imem_ready = 0; dmem_ready = 0; md_done = 0; cls_branch = 0;
    branch_taken = 0; cls_mem = 0; cls_store = 0; cls_muldiv = 0; cls_jump = 0;
    cls_link = 0; cls_trap = 0; exception_valid = 0; cls_wb = 0;
    reset = 1;
    nx(); nx();
    reset = 0;
  endtask

  initial begin
    // reset holds everything even with inputs active
    nx(); nx();
    run_en = 1; imem_ready = 1;
    #1;
    chk("rst.st_a", 32'(st_a), ST_PAUSE); chk("rst.sb_a", 32'(sb_a), 0);
    chk("rst.ca_a", 32'(ca_a), 0);        chk("rst.ret_a", 32'(ret_a), 0);
    chk("rst.st_b", 32'(st_b), ST_PAUSE); chk("rst.ret_b", ret_b, 0);

    // run_en=0 parks in PAUSE
    rst(); imem_ready = 1;
    cyc("hold0", ST_PAUSE, 0); cyc("hold1", ST_PAUSE, 0);

    // ALU op
    rst(); run_en = 1; imem_ready = 1; cls_wb = 1;
    cyc("alu_p", ST_PAUSE, 0); cyc("alu_f", ST_FETCH, FETCH_SB);
    cyc("alu_d", ST_DECODE, B_PC); cyc("alu_e", ST_EXEC, B_Y); cyc("alu_wb", ST_WB, B_RF);
    #1 chk("alu_end.st", 32'(st_a), ST_FETCH); chk("alu_ret", 32'(ret_a), 1);

    // beq not taken
    rst(); run_en = 1; imem_ready = 1; cls_branch = 1;
    cyc("bnt_p", ST_PAUSE, 0); cyc("bnt_f", ST_FETCH, FETCH_SB);
    cyc("bnt_d", ST_DECODE, B_PC); cyc("bnt_j", ST_JUDGE, B_Y);
    #1 chk("bnt_end.st", 32'(st_a), ST_FETCH); chk("bnt_ret", 32'(ret_a), 1);

    // beq taken
    rst(); run_en = 1; imem_ready = 1; cls_branch = 1; branch_taken = 1;
    cyc("bt_p", ST_PAUSE, 0); cyc("bt_f", ST_FETCH, FETCH_SB); cyc("bt_d", ST_DECODE, B_PC);
    cyc("bt_j", ST_JUDGE, B_Y); cyc("bt_e", ST_EXEC, B_Y); cyc("bt_wb", ST_WB, B_PC);
    #1 chk("bt_end.st", 32'(st_a), ST_FETCH); chk("bt_ret", 32'(ret_a), 1);

    // div, md_done on 33rd wait cycle: dut_a completes, dut_b times out at 15
    rst(); run_en = 1; imem_ready = 1; cls_muldiv = 1;
    cyc("div_p", ST_PAUSE, 0); cyc("div_f", ST_FETCH, FETCH_SB);
    cyc("div_d", ST_DECODE, B_PC); cyc("div_e", ST_EXEC, B_MDS);
    for (int k = 1; k <= 33; k++) begin
      md_done = (k == 33);
      #1;
      chk($sformatf("div_w%0d.st", k), 32'(st_a), ST_MDW);
      chk($sformatf("div_w%0d.sb", k), 32'(sb_a), (k == 33) ? 32'(B_HILO) : 32'd0);
      if (k == 15) chk("to_last.st_b", 32'(st_b), ST_MDW);
      if (k == 16) begin
        chk("to_trap.st_b", 32'(st_b), ST_TRAP);
        chk("to_trap.sb_b", 32'(sb_b), 32'(B_EXC | B_PC));
        chk("to_trap.ca_b", 32'(ca_b), 2);
      end
      if (k == 17) begin
        chk("to_fetch.st_b", 32'(st_b), ST_FETCH);
        chk("to_fetch.ca_b", 32'(ca_b), 2);
        chk("to_fetch.ret_b", ret_b, 0);
      end
      if (k == 18) chk("to_clr.ca_b", 32'(ca_b), 0);
      nx();
    end
    md_done = 0;
    #1 chk("div_end.st", 32'(st_a), ST_FETCH); chk("div_ret", 32'(ret_a), 1);
    chk("div_ca", 32'(ca_a), 0);

    // done on exactly the MAX_WAIT cycle beats the timeout (dut_b)
    rst(); run_en = 1; imem_ready = 1; cls_muldiv = 1;
    repeat (4) nx();
    for (int k = 1; k <= 15; k++) begin
      md_done = (k == 15);
      #1 chk($sformatf("edge_w%0d.st_b", k), 32'(st_b), ST_MDW);
      if (k == 15) chk("edge.sb_b", 32'(sb_b), 32'(B_HILO));
      nx();
    end
    md_done = 0;
    #1 chk("edge_end.st_b", 32'(st_b), ST_FETCH); chk("edge.ret_b", ret_b, 1);
    chk("edge.ca_b", 32'(ca_b), 0);

    // store, stale handshakes before MEM_WAIT, ready on 3rd wait cycle
    rst(); run_en = 1; imem_ready = 1; cls_mem = 1; cls_store = 1; cls_wb = 1;
    dmem_ready = 1; md_done = 1;
    cyc("st_p", ST_PAUSE, 0); cyc("st_f", ST_FETCH, FETCH_SB);
    cyc("st_d", ST_DECODE, B_PC); cyc("st_e", ST_EXEC, B_DREQ);
    for (int k = 1; k <= 3; k++) begin
      dmem_ready = (k == 3);
      cyc($sformatf("st_w%0d", k), ST_MEMW, B_DREQ | B_DW);
    end
    dmem_ready = 0; md_done = 0;
    cyc("st_wb", ST_WB, 0);
    #1 chk("st_end.st", 32'(st_a), ST_FETCH); chk("st_ret", 32'(ret_a), 1);

    // load, ready on first wait cycle
    rst(); run_en = 1; imem_ready = 1; cls_mem = 1; cls_wb = 1; dmem_ready = 1;
    repeat (3) nx();
    cyc("ld_e", ST_EXEC, B_DREQ); cyc("ld_w", ST_MEMW, B_DREQ); cyc("ld_wb", ST_WB, B_RF);
    #1 chk("ld_ret", 32'(ret_a), 1);

    // syscall with exception permitted (muldiv also set: trap has priority)
    rst(); run_en = 1; imem_ready = 1; cls_trap = 1; cls_muldiv = 1; exception_valid = 1;
    repeat (3) nx();
    cyc("sc_e", ST_EXEC, 0);
    #1 chk("sc_ca", 32'(ca_a), 1);
    cyc("sc_t", ST_TRAP, B_EXC | B_PC);
    #1 chk("sc_f.st", 32'(st_a), ST_FETCH); chk("sc_ret", 32'(ret_a), 0);
    chk("sc_hold.ca", 32'(ca_a), 1);
    nx();
    #1 chk("sc_clr.ca", 32'(ca_a), 0);

    // syscall without exception: retires
    rst(); run_en = 1; imem_ready = 1; cls_trap = 1; cls_muldiv = 1;
    repeat (3) nx();
    cyc("scn_e", ST_EXEC, 0);
    #1 chk("scn.st", 32'(st_a), ST_FETCH); chk("scn_ret", 32'(ret_a), 1);

    // jal
    rst(); run_en = 1; imem_ready = 1; cls_jump = 1; cls_link = 1; cls_wb = 1;
    repeat (3) nx();
    cyc("jal_e", ST_EXEC, B_PC | B_RF);
    #1 chk("jal.st", 32'(st_a), ST_FETCH); chk("jal_ret", 32'(ret_a), 1);

    // reset mid MD_WAIT aborts at once
    rst(); run_en = 1; imem_ready = 1; cls_muldiv = 1;
    repeat (4) nx();
    cyc("mr_w1", ST_MDW, 0);
    md_done = 1; reset = 1;
    #1 chk("mr.st", 32'(st_a), ST_PAUSE); chk("mr.sb", 32'(sb_a), 0);

    // retire counter wrap on RET_W=4
    rst(); run_en = 1; imem_ready = 1; cls_jump = 1;
    repeat (46) nx();
    #1 chk("wrap15", 32'(ret_a), 15);
    repeat (3) nx();
    #1 chk("wrap0", 32'(ret_a), 0); chk("wrap_b16", ret_b, 16);

    // run_en dropped mid-instruction: finish, then PAUSE
    rst(); run_en = 1; imem_ready = 1; cls_wb = 1;
    cyc("rd_p", ST_PAUSE, 0); cyc("rd_f", ST_FETCH, FETCH_SB);
    run_en = 0;
    cyc("rd_d", ST_DECODE, B_PC); cyc("rd_e", ST_EXEC, B_Y); cyc("rd_wb", ST_WB, B_RF);
    #1 chk("rd_ret", 32'(ret_a), 1);
    cyc("rd_p1", ST_PAUSE, 0); cyc("rd_p2", ST_PAUSE, 0);

    // FETCH timeout on dut_b
    rst(); run_en = 1;
    nx();
    repeat (14) nx();
    #1 chk("ft_last.st_b", 32'(st_b), ST_FETCH);
    nx();
    #1 chk("ft.st_b", 32'(st_b), ST_TRAP); chk("ft.ca_b", 32'(ca_b), 2);
    chk("ft.st_a", 32'(st_a), ST_FETCH);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
